// File: rtl/lane_sr_if.sv
// Bus bundle for lane_sr: control, per-lane data/valid in, exit and parallel outputs.
// Combinational bundle only; no handshake, every request is accepted on the edge.
interface lane_sr_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int LANES  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                          clear;
    logic                          load_enable;
    logic                          shift_enable;
    logic                          circ_enable;
    logic [LANES-1:0]              lane_mask;
    logic [LANES*DATA_W-1:0]       data_in;
    logic [LANES-1:0]              valid_in;
    logic [LANES*DEPTH*DATA_W-1:0] parallel_in;
    logic [LANES*DATA_W-1:0]       data_out;
    logic [LANES-1:0]              valid_out;
    logic [LANES*DEPTH*DATA_W-1:0] parallel_out;
    logic [LANES*CW-1:0]           fill_count;
    logic [LANES-1:0]              full;
    logic [LANES-1:0]              empty;

    modport master (
        output clear, load_enable, shift_enable, circ_enable, lane_mask,
               data_in, valid_in, parallel_in,
        input  data_out, valid_out, parallel_out, fill_count, full, empty
    );

    modport slave (
        input  clear, load_enable, shift_enable, circ_enable, lane_mask,
               data_in, valid_in, parallel_in,
        output data_out, valid_out, parallel_out, fill_count, full, empty
    );
endinterface

// File: rtl/lane_sr.sv
// Multi-lane word shift register with per-stage valid, lane mask, parallel load and rotate.
// A word reaches data_out after DEPTH shifts; no backpressure, the exit word is dropped on shift.
module lane_sr #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 7,
    parameter int LANES     = 4,
    parameter int MSB_FIRST = 0
) (
    input logic     clk,
    input logic     n_rst,
    lane_sr_if.slave bus
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int ENTRY = (MSB_FIRST != 0) ? 0 : DEPTH - 1;
    localparam int EXIT  = (MSB_FIRST != 0) ? DEPTH - 1 : 0;

    typedef logic [DEPTH-1:0][DATA_W-1:0] lane_dat_t;

    lane_dat_t        data_q  [LANES];
    logic [DEPTH-1:0] valid_q [LANES];
    lane_dat_t        shf_dat [LANES];
    logic [DEPTH-1:0] shf_vld [LANES];
    logic [CW-1:0]    fill    [LANES];

    // Shift the whole lane vector one stage toward EXIT, then overwrite the entry stage.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (MSB_FIRST != 0) begin
                shf_dat[l] = data_q[l] << DATA_W;
                shf_vld[l] = valid_q[l] << 1;
            end else begin
                shf_dat[l] = data_q[l] >> DATA_W;
                shf_vld[l] = valid_q[l] >> 1;
            end
            if (bus.circ_enable) begin
                shf_dat[l][ENTRY] = data_q[l][EXIT];
                shf_vld[l][ENTRY] = valid_q[l][EXIT];
            end else begin
                shf_dat[l][ENTRY] = bus.data_in[l*DATA_W +: DATA_W];
                shf_vld[l][ENTRY] = bus.valid_in[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || bus.clear) begin
            for (int l = 0; l < LANES; l++) begin
                data_q[l]  <= '0;
                valid_q[l] <= '0;
            end
        end else if (bus.load_enable) begin
            for (int l = 0; l < LANES; l++) begin
                data_q[l]  <= bus.parallel_in[l*DEPTH*DATA_W +: DEPTH*DATA_W];
                valid_q[l] <= '1;
            end
        end else if (bus.shift_enable) begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.lane_mask[l]) begin
                    data_q[l]  <= shf_dat[l];
                    valid_q[l] <= shf_vld[l];
                end
            end
        end
    end

    always_comb begin
        bus.data_out     = '0;
        bus.valid_out    = '0;
        bus.parallel_out = '0;
        bus.fill_count   = '0;
        bus.full         = '0;
        bus.empty        = '0;
        for (int l = 0; l < LANES; l++) begin
            fill[l] = CW'($countones(valid_q[l]));
            bus.data_out[l*DATA_W +: DATA_W]                 = data_q[l][EXIT];
            bus.valid_out[l]                                 = valid_q[l][EXIT];
            bus.parallel_out[l*DEPTH*DATA_W +: DEPTH*DATA_W] = data_q[l];
            bus.fill_count[l*CW +: CW]                       = fill[l];
            bus.full[l]                                      = (fill[l] == CW'(DEPTH));
            bus.empty[l]                                     = (fill[l] == '0);
        end
    end
endmodule
